// File: rtl/pipeline_regfile_sb_if.sv
// Register-file bus: WB write port, two read ports, ID issue notification and hazard flags.
// The decode/writeback side drives through master; the register file attaches as slave.
interface pipeline_regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              i_regWr;
    logic [ADDR_W-1:0] i_rw;
    logic [DATA_W-1:0] i_busW;
    logic [ADDR_W-1:0] i_ra;
    logic [ADDR_W-1:0] i_rb;
    logic [DATA_W-1:0] o_busA;
    logic [DATA_W-1:0] o_busB;
    logic              i_issue;
    logic [ADDR_W-1:0] i_issueRd;
    logic              o_hazA;
    logic              o_hazB;
    logic              o_hazRd;
    logic              o_busy;

    modport master (
        output i_regWr, i_rw, i_busW, i_ra, i_rb, i_issue, i_issueRd,
        input  o_busA, o_busB, o_hazA, o_hazB, o_hazRd, o_busy
    );

    modport slave (
        input  i_regWr, i_rw, i_busW, i_ra, i_rb, i_issue, i_issueRd,
        output o_busA, o_busB, o_hazA, o_hazB, o_hazRd, o_busy
    );
endinterface

// File: rtl/pipeline_regfile_sb.sv
// GPR file with write-first bypass plus a per-register pending-write scoreboard
// that flags RAW (per read port) and WAW (issue destination) hazards to decode.
module pipeline_regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic                  i_clk,
    input logic                  i_rst,
    pipeline_regfile_sb_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [Depth-1:0][DATA_W-1:0] regs_d, regs_q;
    logic [Depth-1:0]             pend_d, pend_q;
    logic [Depth-1:0]             pend_clr;

    logic zero_ra, zero_rb, zero_rw, zero_issue;
    logic wr_ra, wr_rb, wr_issue;

    always_comb begin
        zero_ra    = ZERO_REG && (bus.i_ra == '0);
        zero_rb    = ZERO_REG && (bus.i_rb == '0);
        zero_rw    = ZERO_REG && (bus.i_rw == '0);
        zero_issue = ZERO_REG && (bus.i_issueRd == '0);
        wr_ra      = bus.i_regWr && (bus.i_rw == bus.i_ra);
        wr_rb      = bus.i_regWr && (bus.i_rw == bus.i_rb);
        wr_issue   = bus.i_regWr && (bus.i_rw == bus.i_issueRd);
    end

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (bus.i_regWr && !zero_rw) begin
            regs_d[bus.i_rw] = bus.i_busW;
        end
        if (bus.i_regWr) begin
            pend_d[bus.i_rw] = 1'b0;
        end
        // Applied after the clear so a new producer supersedes the retiring one.
        if (bus.i_issue && !zero_issue) begin
            pend_d[bus.i_issueRd] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        if (zero_ra) begin
            bus.o_busA = '0;
        end else if (wr_ra) begin
            bus.o_busA = bus.i_busW;
        end else begin
            bus.o_busA = regs_q[bus.i_ra];
        end

        if (zero_rb) begin
            bus.o_busB = '0;
        end else if (wr_rb) begin
            bus.o_busB = bus.i_busW;
        end else begin
            bus.o_busB = regs_q[bus.i_rb];
        end
    end

    always_comb begin
        pend_clr = pend_q;
        if (bus.i_regWr) begin
            pend_clr[bus.i_rw] = 1'b0;
        end
        bus.o_hazA  = pend_q[bus.i_ra] && !wr_ra && !zero_ra;
        bus.o_hazB  = pend_q[bus.i_rb] && !wr_rb && !zero_rb;
        bus.o_hazRd = bus.i_issue && pend_q[bus.i_issueRd] && !wr_issue && !zero_issue;
        bus.o_busy  = |pend_clr;
    end
endmodule

// File: doc/pipeline_regfile_sb.md
# pipeline_regfile_sb

Parametrised general-purpose register file with an integrated write-pending scoreboard for the pipelined MIPS32 datapath. It provides two combinational read ports with write-first bypass and one synchronous write port. It also tracks which destination registers have an in-flight producer, so decode can raise stalls without a separate hazard unit. It sits in the ID stage: reads feed the ID/EX operands, writes arrive from WB, and issue notifications arrive from ID when an instruction leaves decode.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2^ADDR_W
- ZERO_REG, 1, 1: index 0 reads 0, ignores writes, never becomes pending; 0: index 0 is an ordinary register

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_regWr  in  1  WB write enable
- i_rw  in  ADDR_W  WB write index
- i_busW  in  DATA_W  WB write data
- i_ra  in  ADDR_W  read port A index
- i_rb  in  ADDR_W  read port B index
- o_busA  out  DATA_W  read port A data
- o_busB  out  DATA_W  read port B data
- i_issue  in  1  an instruction with destination i_issueRd leaves ID this cycle
- i_issueRd  in  ADDR_W  destination index of the issuing instruction
- o_hazA  out  1  port A source has an unresolved pending write
- o_hazB  out  1  port B source has an unresolved pending write
- o_hazRd  out  1  i_issueRd is already pending (WAW); decode must not assert i_issue
- o_busy  out  1  at least one register is pending

## Operation
- Storage: 2^ADDR_W x DATA_W data array plus a 2^ADDR_W pending-bit vector pend[].
- Reset: when i_rst=1 at a clock edge, every register is cleared to 0 and every pend bit is cleared. i_regWr and i_issue are ignored in that cycle. Reset mid-operation discards all in-flight state.
- Write: when i_regWr=1, registers[i_rw] is set to i_busW at the edge. When ZERO_REG=1 and i_rw=0, the write is dropped.
- Read (port A; port B is identical):
  - ZERO_REG=1 and i_ra=0: output 0.
  - Else, if i_regWr=1 and i_rw=i_ra: output i_busW (write-first bypass).
  - Else: output registers[i_ra].
- Scoreboard update at the edge:
  - Clear pend[i_rw] when i_regWr=1.
  - Set pend[i_issueRd] when i_issue=1, subject to ZERO_REG exclusion of index 0.
  - If both target the same index in one cycle, set wins: a new producer supersedes the retiring one.
- Hazards:
  - o_hazA = pend[i_ra] AND NOT(i_regWr AND i_rw=i_ra) AND NOT(ZERO_REG AND i_ra=0); o_hazB is analogous. A writeback in the current cycle resolves the hazard through the bypass.
  - o_hazRd = i_issue AND pend[i_issueRd] AND NOT(i_regWr AND i_rw=i_issueRd) AND NOT(ZERO_REG AND i_issueRd=0).
  - Issuing while o_hazRd=1 is a protocol violation: the pend bit stays 1, and the block does not count producers.
- o_busy = OR of all pend bits, after any clear in the current cycle is applied (combinational).

## Timing
- Read data and all hazard outputs are combinational from the current inputs and state: 0-cycle latency.
- A write is visible through the array on the cycle after the edge. In the write cycle itself it is visible through the bypass.
- A pend bit set by i_issue at edge N affects o_hazA/o_hazB from cycle N+1.
- Output values after reset: o_busA=o_busB=0 for all indices, o_hazA=o_hazB=o_hazRd=0, o_busy=0.
- No handshake back-pressure: the block always accepts a write and an issue every cycle.

## Test plan
- Reset clear: write 0xDEADBEEF to r5, pulse i_rst for one cycle, then read i_ra=5 -> o_busA=0; o_busy=0.
- Bypass and r0: with i_regWr=1, i_rw=7, i_busW=0x12345678, i_ra=7 in the same cycle -> o_busA=0x12345678. Write 0xFFFFFFFF to r0 with ZERO_REG=1 -> a later read of r0 returns 0.
- RAW stall: issue rd=3 at edge N, then set i_ra=3 -> o_hazA=1 and o_busy=1 until the WB cycle. In the WB cycle with i_rw=3, i_busW=0xA5 -> o_hazA=0 and o_busA=0xA5. Next cycle pend[3]=0.
- Simultaneous set and clear: i_issue with rd=9 and i_regWr with rw=9 in the same cycle -> pend[9]=1 afterwards; o_hazB=1 for i_rb=9.
- WAW flag: with pend[4]=1, assert i_issue with rd=4 and no writeback -> o_hazRd=1. Same request while WB writes r4 -> o_hazRd=0.
- Parameter sweep: DATA_W=16, ADDR_W=3, ZERO_REG=0 -> write 0xBEEF to r0 and read back 0xBEEF; r7 write/read round-trips correctly.
